// File: rtl/sc_microseq_pkg.sv
// Shared types and constants for the control-store microsequencer.
// The single-step debug feature is selected with the SC_MICROSEQ_STEP_EN macro.
package sc_microseq_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEC_W  = 8;
  localparam int unsigned COND_W = 3;
  localparam int unsigned FLAG_W = 4;
  localparam logic [ADDR_W-1:0] RESET_ADDR = 11'd0;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [COND_W-1:0] {
    COND_NEXT   = 3'd0,
    COND_N      = 3'd1,
    COND_Z      = 3'd2,
    COND_V      = 3'd3,
    COND_C      = 3'd4,
    COND_IR13   = 3'd5,
    COND_JUMP   = 3'd6,
    COND_DECODE = 3'd7
  } cond_e;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_RUN  = 3'd1,
    S_WAIT = 3'd2,
    S_HALT = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  // Opcode dispatch lands in the upper half of the store, four words per opcode.
  function automatic logic [ADDR_W-1:0] decode_addr(input logic [DEC_W-1:0] dec);
    return {1'b1, dec, 2'b00};
  endfunction

endpackage

// File: rtl/sc_microseq_nextaddr.sv
// Combinational next-address selection: COND mux over the ALU flags, IR13,
// the jump field and the opcode dispatch, plus the wrapping micro-PC incrementer.
module sc_microseq_nextaddr
  import sc_microseq_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [DEC_W-1:0]  decode,
  input  logic [FLAG_W-1:0] flags,
  input  logic              ir13,
  input  logic [ADDR_W-1:0] upc,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] inc;

  always_comb begin
    inc       = upc + 11'd1;
    next_addr = inc;
    case (cond)
      COND_NEXT:   next_addr = inc;
      COND_N:      next_addr = flags[FLAG_N] ? jump_addr : inc;
      COND_Z:      next_addr = flags[FLAG_Z] ? jump_addr : inc;
      COND_V:      next_addr = flags[FLAG_V] ? jump_addr : inc;
      COND_C:      next_addr = flags[FLAG_C] ? jump_addr : inc;
      COND_IR13:   next_addr = ir13 ? jump_addr : inc;
      COND_JUMP:   next_addr = jump_addr;
      COND_DECODE: next_addr = decode_addr(decode);
      default:     next_addr = inc;
    endcase
  end

endmodule

// File: rtl/sc_microsequencer.sv
// Micro-PC register and sequencing FSM with memory stall and halt detection.
// Optional single-step mode (Step_In port, S_HOLD state) under SC_MICROSEQ_STEP_EN.
module sc_microsequencer
  import sc_microseq_pkg::*;
(
  input  logic              SC_MICROSEQ_CLOCK_50,
  input  logic              SC_MICROSEQ_Reset_InLow,
  input  logic [COND_W-1:0] SC_MICROSEQ_Cond_In,
  input  logic [ADDR_W-1:0] SC_MICROSEQ_JumpAddr_In,
  input  logic [DEC_W-1:0]  SC_MICROSEQ_Decode_In,
  input  logic [FLAG_W-1:0] SC_MICROSEQ_Flags_In,
  input  logic              SC_MICROSEQ_IR13_In,
  input  logic              SC_MICROSEQ_MemRd_In,
  input  logic              SC_MICROSEQ_MemWr_In,
  input  logic              SC_MICROSEQ_MemAck_In,
`ifdef SC_MICROSEQ_STEP_EN
  input  logic              SC_MICROSEQ_Step_In,
`endif
  output logic [ADDR_W-1:0] SC_MICROSEQ_CSAddr_Out,
  output logic              SC_MICROSEQ_MemReq_Out,
  output logic              SC_MICROSEQ_DPEnable_Out,
  output logic              SC_MICROSEQ_Halted_Out
);

`ifdef SC_MICROSEQ_STEP_EN
  localparam state_e AFTER_COMMIT = S_HOLD;
`else
  localparam state_e AFTER_COMMIT = S_RUN;
`endif

  state_e            state;
  logic [ADDR_W-1:0] upc;
  logic              halted;
  logic [ADDR_W-1:0] next_addr;
  logic              mem_op;

  assign mem_op = SC_MICROSEQ_MemRd_In | SC_MICROSEQ_MemWr_In;

  sc_microseq_nextaddr u_nextaddr (
    .cond      (SC_MICROSEQ_Cond_In),
    .jump_addr (SC_MICROSEQ_JumpAddr_In),
    .decode    (SC_MICROSEQ_Decode_In),
    .flags     (SC_MICROSEQ_Flags_In),
    .ir13      (SC_MICROSEQ_IR13_In),
    .upc       (upc),
    .next_addr (next_addr)
  );

  // Stall and request depend on this cycle's ack, so they cannot wait for an edge.
  always_comb begin
    SC_MICROSEQ_MemReq_Out   = 1'b0;
    SC_MICROSEQ_DPEnable_Out = 1'b0;
    case (state)
      S_RUN: begin
        SC_MICROSEQ_MemReq_Out   = mem_op;
        SC_MICROSEQ_DPEnable_Out = !(mem_op && !SC_MICROSEQ_MemAck_In);
      end
      S_WAIT: begin
        SC_MICROSEQ_MemReq_Out   = mem_op;
        SC_MICROSEQ_DPEnable_Out = SC_MICROSEQ_MemAck_In;
      end
      default: begin
        SC_MICROSEQ_MemReq_Out   = 1'b0;
        SC_MICROSEQ_DPEnable_Out = 1'b0;
      end
    endcase
  end

  // Sequencing FSM; the halt idiom is a self-jump and is only left by reset.
  always_ff @(posedge SC_MICROSEQ_CLOCK_50 or negedge SC_MICROSEQ_Reset_InLow) begin
    if (!SC_MICROSEQ_Reset_InLow) begin
      state  <= S_BOOT;
      upc    <= RESET_ADDR;
      halted <= 1'b0;
    end else begin
      case (state)
        S_BOOT: state <= AFTER_COMMIT;
        S_RUN: begin
          if (mem_op && !SC_MICROSEQ_MemAck_In) begin
            state <= S_WAIT;
          end else if (SC_MICROSEQ_Cond_In == COND_JUMP &&
                       SC_MICROSEQ_JumpAddr_In == upc) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            upc   <= next_addr;
            state <= AFTER_COMMIT;
          end
        end
        S_WAIT: begin
          if (SC_MICROSEQ_MemAck_In) begin
            upc   <= next_addr;
            state <= AFTER_COMMIT;
          end else begin
            state <= S_WAIT;
          end
        end
        S_HALT: state <= S_HALT;
`ifdef SC_MICROSEQ_STEP_EN
        S_HOLD: state <= SC_MICROSEQ_Step_In ? S_RUN : S_HOLD;
`endif
        default: state <= S_BOOT;
      endcase
    end
  end

  assign SC_MICROSEQ_CSAddr_Out = upc;
  assign SC_MICROSEQ_Halted_Out = halted;

endmodule
